resp_frame_builder: RTL

- Parametrised successor to the fixed-format response frame builder in the UART-AXI4 bridge, between the bridge command engine and the UART TX FIFO.
- Emits device-to-host response frames: SOF, STATUS, CMD, optional ADDR, optional DATA, CRC8.
- Address width, maximum payload, SOF value and inter-frame gap are parameters.
- Payload is pulled byte-by-byte over a valid/ready stream instead of a 64-byte array; adds abort and a frame counter.

---
 rtl/resp_frame_pkg.sv | 29 ++
 rtl/resp_frame_builder_if.sv | 33 +++
 rtl/crc8_engine.sv | 21 ++
 rtl/resp_frame_builder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/resp_frame_pkg.sv
// rtl/resp_frame_pkg.sv - shared types, constants and CRC-8 step for the response frame builder
package resp_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_STATUS,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_GAP
    } resp_state_t;

    localparam logic [7:0] SOF_DEVICE_TO_HOST = 8'h5A;
    localparam logic [7:0] STATUS_OK          = 8'h00;
    localparam logic [7:0] CRC8_POLY          = 8'h07;

    // MSB-first CRC-8, no reflection, no final XOR
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/resp_frame_builder_if.sv
// rtl/resp_frame_builder_if.sv - request, payload stream and TX FIFO signals of the frame builder
interface resp_frame_builder_if #(
    parameter int ADDR_BYTES     = 4,
    parameter int MAX_DATA_BYTES = 64
);
    localparam int LEN_W = $clog2(MAX_DATA_BYTES + 1);

    logic                    req_valid;
    logic                    req_ready;
    logic [7:0]              req_status;
    logic [7:0]              req_cmd;
    logic [8*ADDR_BYTES-1:0] req_addr;
    logic [LEN_W-1:0]        req_len;
    logic                    data_valid;
    logic [7:0]              data_byte;
    logic                    data_ready;
    logic [7:0]              tx_fifo_data;
    logic                    tx_fifo_wr_en;
    logic                    tx_fifo_full;

    modport master (
        output req_valid, req_status, req_cmd, req_addr, req_len,
        output data_valid, data_byte, tx_fifo_full,
        input  req_ready, data_ready, tx_fifo_data, tx_fifo_wr_en
    );

    modport slave (
        input  req_valid, req_status, req_cmd, req_addr, req_len,
        input  data_valid, data_byte, tx_fifo_full,
        output req_ready, data_ready, tx_fifo_data, tx_fifo_wr_en
    );

endinterface

// File: rtl/crc8_engine.sv
// rtl/crc8_engine.sv - running CRC-8 register with byte enable and synchronous clear
module crc8_engine
    import resp_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_update(crc, data);
        end
    end

endmodule

// File: rtl/resp_frame_builder.sv
// rtl/resp_frame_builder.sv - emits SOF/STATUS/CMD/[ADDR]/[DATA]/CRC8 response frames into the UART TX FIFO
module resp_frame_builder
    import resp_frame_pkg::*;
#(
    parameter int         ADDR_BYTES     = 4,
    parameter int         MAX_DATA_BYTES = 64,
    parameter logic [7:0] SOF_BYTE       = 8'h5A,
    parameter logic [7:0] STATUS_OK      = 8'h00,
    parameter int         IFG_CYCLES     = 1,
    localparam int        LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    resp_frame_builder_if.slave  bus,
    input  logic                 abort,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_aborted,
    output logic [15:0]          frame_count
);

    resp_state_t             state;
    logic [7:0]              status_q;
    logic [7:0]              cmd_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        data_idx;
    logic [3:0]              addr_idx;
    logic [7:0]              gap_cnt;
    logic                    has_payload;
    logic [7:0]              crc;
    logic [7:0]              tx_byte;
    logic                    emit_state;
    logic                    wr;
    logic                    crc_en;

    // A byte goes out only when the FIFO has room, no abort is pending and, in DATA, a byte is offered
    always_comb begin
        emit_state = (state != ST_IDLE) && (state != ST_GAP);
        wr         = emit_state && !bus.tx_fifo_full && !abort &&
                     ((state != ST_DATA) || bus.data_valid);
        crc_en     = wr && (state inside {ST_STATUS, ST_CMD, ST_ADDR, ST_DATA});
        case (state)
            ST_SOF:    tx_byte = SOF_BYTE;
            ST_STATUS: tx_byte = status_q;
            ST_CMD:    tx_byte = cmd_q;
            ST_ADDR:   tx_byte = addr_q[7:0];
            ST_DATA:   tx_byte = bus.data_byte;
            ST_CRC:    tx_byte = crc;
            default:   tx_byte = 8'h00;
        endcase
    end

    assign bus.tx_fifo_wr_en = wr;
    assign bus.tx_fifo_data  = wr ? tx_byte : 8'h00;
    assign bus.data_ready    = (state == ST_DATA) && !bus.tx_fifo_full && !abort;
    assign bus.req_ready     = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);

    crc8_engine u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .en    (crc_en),
        .data  (tx_byte),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            status_q      <= 8'h00;
            cmd_q         <= 8'h00;
            addr_q        <= '0;
            len_q         <= '0;
            data_idx      <= '0;
            addr_idx      <= 4'd0;
            gap_cnt       <= 8'd0;
            has_payload   <= 1'b0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
            frame_count   <= 16'd0;
        end else begin
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state         <= ST_IDLE;
                frame_aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.req_valid) begin
                            status_q    <= bus.req_status;
                            cmd_q       <= bus.req_cmd;
                            addr_q      <= bus.req_addr;
                            len_q       <= (bus.req_len > LEN_W'(MAX_DATA_BYTES)) ?
                                           LEN_W'(MAX_DATA_BYTES) : bus.req_len;
                            has_payload <= bus.req_cmd[7] && (bus.req_status == STATUS_OK);
                            addr_idx    <= 4'd0;
                            data_idx    <= '0;
                            state       <= ST_SOF;
                        end
                    end
                    ST_SOF:    if (wr) state <= ST_STATUS;
                    ST_STATUS: if (wr) state <= ST_CMD;
                    ST_CMD:    if (wr) state <= has_payload ? ST_ADDR : ST_CRC;
                    ST_ADDR: begin
                        if (wr) begin
                            addr_q <= addr_q >> 8;
                            if (addr_idx == 4'(ADDR_BYTES - 1)) begin
                                state <= (len_q != '0) ? ST_DATA : ST_CRC;
                            end else begin
                                addr_idx <= addr_idx + 4'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (wr) begin
                            if (data_idx == len_q - LEN_W'(1)) begin
                                state <= ST_CRC;
                            end else begin
                                data_idx <= data_idx + LEN_W'(1);
                            end
                        end
                    end
                    ST_CRC: begin
                        if (wr) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            gap_cnt     <= 8'd0;
                            state       <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 8'(IFG_CYCLES - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
